// File: rtl/blink_input_loader.sv
// blink_input_loader: assembles the round-key block K0, the tweak T and the
// data block P for the Blink core from a stream of W-bit words.
// A frame is an optional key section, then a tweak section, then a data
// section, each loaded least-significant word first. K0 and key_valid persist
// across frames so the key can be reused by frames without a key section.
module blink_input_loader #(
   parameter int N        = 128,
   parameter int ROUND    = 16,
   parameter int TWEAKLEN = 256,
   parameter int W        = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [W-1:0]              in_data,
   input  logic                      in_new_key,
   input  logic                      in_enc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      enc,
   output logic [N*(ROUND/2)-1:0]    K0,
   output logic [TWEAKLEN-1:0]       T,
   output logic [N-1:0]              P,
   output logic                      key_valid,
   output logic                      err
);

   localparam int KW       = N * (ROUND / 2);
   localparam int KEYWORDS = KW / W;
   localparam int TWKWORDS = TWEAKLEN / W;
   localparam int DATWORDS = N / W;

   localparam logic [4:0] KEY_LAST = 5'(KEYWORDS - 1);
   localparam logic [4:0] TWK_LAST = 5'(TWKWORDS - 1);
   localparam logic [4:0] DAT_LAST = 5'(DATWORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      KEY,
      TWK,
      DAT,
      OUT
   } state_t;

   state_t     state;
   logic [4:0] cnt;
   logic       beat;

   // Handshake decodes depend only on the state register.
   always_comb begin
      in_ready  = (state != OUT);
      out_valid = (state == OUT);
      beat      = in_valid && in_ready;
   end

   // Frame sequencing, word placement and key bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         K0        <= '0;
         T         <= '0;
         P         <= '0;
         enc       <= 1'b0;
         key_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (beat) begin
                  if (in_new_key) begin
                     enc         <= in_enc;
                     K0[W-1:0]   <= in_data;
                     key_valid   <= 1'b0;
                     cnt         <= 5'd1;
                     state       <= KEY;
                  end else if (key_valid) begin
                     enc         <= in_enc;
                     T[W-1:0]    <= in_data;
                     cnt         <= 5'd1;
                     state       <= TWK;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            KEY: begin
               if (beat) begin
                  K0[cnt*W +: W] <= in_data;
                  if (cnt == KEY_LAST) begin
                     key_valid <= 1'b1;
                     cnt       <= '0;
                     state     <= TWK;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            TWK: begin
               if (beat) begin
                  T[cnt[2:0]*W +: W] <= in_data;
                  if (cnt == TWK_LAST) begin
                     cnt   <= '0;
                     state <= DAT;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            DAT: begin
               if (beat) begin
                  P[cnt[1:0]*W +: W] <= in_data;
                  if (cnt == DAT_LAST) begin
                     cnt   <= '0;
                     state <= OUT;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/blink_input_loader.md
BLINK_INPUT_LOADER -- requirements
Module: blink_input_loader

Interface
REQ-001 Parameters SHALL be: N, 128, cipher block width; ROUND, 16, round count; TWEAKLEN, 256, tweak width; W, 32, input word width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-low reset.
REQ-003 in_valid  in  1  upstream word valid.
REQ-004 in_ready  out  1  loader accepts a word this cycle.
REQ-005 in_data  in  W  input word.
REQ-006 in_new_key  in  1  first beat of a frame: 1 = frame carries a key section; sampled only on the first beat.
REQ-007 in_enc  in  1  direction for the frame: 1 = encrypt; sampled only on the first beat.
REQ-008 out_valid  out  1  K0/T/P/enc complete and stable for the Blink core.
REQ-009 out_ready  in  1  downstream controller takes the operands.
REQ-010 enc  out  1  registered direction, drives the core enc input.
REQ-011 K0  out  N*(ROUND/2)=1024  round-key block.
REQ-012 T  out  TWEAKLEN  tweak.
REQ-013 P  out  N  plaintext or ciphertext block.
REQ-014 key_valid  out  1  K0 holds a fully loaded key.
REQ-015 err  out  1  one-cycle pulse: frame rejected.

Function
REQ-016 Frame layout SHALL be an optional key section of 32 words, then a tweak section of 8 words, then a data section of 4 words. This gives 44 beats with a key and 12 beats without.
REQ-017 Within each section, word i SHALL be written to bits [32i+31:32i], least-significant word first.
REQ-018 A beat SHALL transfer only when in_valid && in_ready are both high on the same rising edge.
REQ-019 FSM states SHALL be IDLE, KEY, TWK, DAT and OUT, with a 5-bit beat counter (cnt).
REQ-020 in_ready SHALL be 1 in IDLE, KEY, TWK and DAT, and 0 in OUT; it SHALL be decoded from the state register with no dependence on in_valid.
REQ-021 IDLE with a beat and in_new_key=1: register in_enc; write K0 word 0; clear key_valid; set cnt=1; go to KEY.
REQ-022 IDLE with a beat, in_new_key=0 and key_valid=1: register in_enc; write T word 0; set cnt=1; go to TWK.
REQ-023 IDLE with a beat, in_new_key=0 and key_valid=0: discard the word; pulse err on the next cycle; stay in IDLE.
REQ-024 KEY: each beat writes K0 word cnt and increments cnt. The beat with cnt=31 SHALL set key_valid, reset cnt to 0 and go to TWK.
REQ-025 TWK: each beat writes T word cnt. The beat with cnt=7 SHALL reset cnt to 0 and go to DAT.
REQ-026 DAT: each beat writes P word cnt. The beat with cnt=3 SHALL go to OUT.
REQ-027 out_valid SHALL equal (state==OUT), so it rises on the cycle after the last data beat (latency 1).
REQ-028 In OUT, K0, T, P and enc SHALL be stable. out_ready=1 SHALL return the FSM to IDLE on the next cycle. out_valid SHALL hold indefinitely while out_ready=0.
REQ-029 K0 and key_valid SHALL persist across frames until a new key section or reset, enabling key reuse.
REQ-030 T and P SHALL hold their values between frames and be overwritten word by word during loading.
REQ-031 Idle cycles (in_valid=0) inside a section SHALL pause loading without changing cnt or state.
REQ-032 in_new_key and in_enc SHALL be ignored on every beat except the first beat of a frame.
REQ-033 out_ready SHALL be ignored outside OUT.
REQ-034 cnt SHALL never exceed the section length minus 1; there is no wrap beyond the section.

Reset
REQ-035 While rst=0 at a clock edge: state=IDLE, cnt=0, K0=0, T=0, P=0, enc=0, key_valid=0, err=0, out_valid=0.
REQ-036 in_ready SHALL be 1 on the first cycle after rst returns to 1.
REQ-037 Reset during any state SHALL abandon the partial frame and clear key_valid, including a reset asserted in KEY.

Verification
REQ-038 Full frame: 44 beats with in_new_key=1, in_enc=1, and word k = 32'h1000_0000+k -> out_valid rises 1 cycle after beat 43; K0[31:0]=32'h1000_0000; K0[1023:992]=32'h1000_001F; T[31:0]=32'h1000_0020; P[127:96]=32'h1000_002B; enc=1; key_valid=1.
REQ-039 Key reuse: after REQ-038 handshake, a 12-beat frame with in_new_key=0, in_enc=0 and words 32'hA0..32'hAB -> K0 unchanged; T[31:0]=32'hA0; P[127:96]=32'hAB; enc=0.
REQ-040 No key: immediately after reset, one beat with in_new_key=0 -> err=1 for exactly one cycle; state stays IDLE; key_valid=0.
REQ-041 Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid=1, in_ready=0 and all outputs constant; out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-042 Gaps: in_valid toggles 1/0 every cycle through a 44-beat frame -> same result as REQ-038, with out_valid 1 cycle after the last accepted beat.
REQ-043 Mid-key reset: rst=0 for one cycle after 10 key beats -> key_valid=0 and K0=0; a following 12-beat no-key frame -> err pulse on its first beat.
